ic_req_router: RTL

- Request-side stage of the interconnect. Sits between one bus master and ND downstream devices.
- Decodes each master request address to a one-hot device select, passes the request through a single-entry hold register to the selected device, and reports each accepted request to the response-order tracker.
- Unmapped addresses go to an internal error responder. That responder raises an error response which the response mux consumes when the tracker grants slot ND.

---
 rtl/ic_req_router.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ic_req_router.sv
// ---------------------------------------------------------------------------
// ic_req_router
//   Request-side stage of the interconnect. Decodes each master request
//   address to a one-hot device select, forwards the request through a
//   single-entry hold register to the selected device, and reports every
//   accepted request to the response-order tracker. Requests that hit no
//   device are absorbed by an internal error responder, which raises
//   err_rsp_valid until the response mux acknowledges it.
//
// Ports
//   g_clk, g_reset          clock, asynchronous active-high reset
//   m_req/m_gnt             master request handshake
//   m_wen/m_strb/m_addr/
//   m_wdata                 master request payload
//   d_req[ND]/d_gnt[ND]     per-device request handshake
//   d_wen/d_strb/d_addr/
//   d_wdata                 shared device payload (from the hold register)
//   trk_requests[ND+1]      one-hot report of the accepted request,
//                           bit ND = error responder
//   trk_ready               tracker can record a new request
//   err_rsp_valid/ack       pending error response handshake
// ---------------------------------------------------------------------------
module ic_req_router #(
  parameter int                 ND       = 3,
  parameter logic [ND*32-1:0]   DEV_BASE = {32'h4000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [ND*32-1:0]   DEV_MASK = {32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_FC00}
) (
  input  logic          g_clk,
  input  logic          g_reset,
  input  logic          m_req,
  output logic          m_gnt,
  input  logic          m_wen,
  input  logic [3:0]    m_strb,
  input  logic [31:0]   m_addr,
  input  logic [31:0]   m_wdata,
  output logic [ND-1:0] d_req,
  input  logic [ND-1:0] d_gnt,
  output logic          d_wen,
  output logic [3:0]    d_strb,
  output logic [31:0]   d_addr,
  output logic [31:0]   d_wdata,
  output logic [ND:0]   trk_requests,
  input  logic          trk_ready,
  output logic          err_rsp_valid,
  input  logic          err_rsp_ack
);

  logic          hold_valid_q, hold_valid_d;
  logic [ND-1:0] hold_sel_q,   hold_sel_d;
  logic          hold_wen_q,   hold_wen_d;
  logic [3:0]    hold_strb_q,  hold_strb_d;
  logic [31:0]   hold_addr_q,  hold_addr_d;
  logic [31:0]   hold_wdata_q, hold_wdata_d;
  logic          err_pending_q, err_pending_d;

  logic [ND-1:0] sel;
  logic          unmapped;
  logic          done;
  logic          accept;

  // Address decode: only the lowest-index hit is kept so that overlapping
  // regions still yield a one-hot select.
  always_comb begin
    logic found;
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < ND; i++) begin
      if (!found && ((m_addr & DEV_MASK[32*i +: 32]) == DEV_BASE[32*i +: 32])) begin
        sel[i] = 1'b1;
        found  = 1'b1;
      end
    end
    unmapped = !found;
  end

  assign d_req   = hold_sel_q & {ND{hold_valid_q}};
  assign d_wen   = hold_wen_q;
  assign d_strb  = hold_strb_q;
  assign d_addr  = hold_addr_q;
  assign d_wdata = hold_wdata_q;

  assign err_rsp_valid = err_pending_q;

  assign done = |(d_req & d_gnt);

  // The hold register may accept a new request in the same cycle it drains.
  // Reset gates the grant so no combinational output is live during reset.
  assign m_gnt  = !g_reset && trk_ready && !err_pending_q && (!hold_valid_q || done);
  assign accept = m_req && m_gnt;

  assign trk_requests = accept ? {unmapped, sel} : '0;

  always_comb begin
    hold_valid_d  = hold_valid_q;
    hold_sel_d    = hold_sel_q;
    hold_wen_d    = hold_wen_q;
    hold_strb_d   = hold_strb_q;
    hold_addr_d   = hold_addr_q;
    hold_wdata_d  = hold_wdata_q;
    err_pending_d = err_pending_q;

    if (done) begin
      hold_valid_d = 1'b0;
    end

    // A mapped accept overrides the drain so back-to-back requests see no bubble.
    if (accept && !unmapped) begin
      hold_valid_d = 1'b1;
      hold_sel_d   = sel;
      hold_wen_d   = m_wen;
      hold_strb_d  = m_strb;
      hold_addr_d  = m_addr;
      hold_wdata_d = m_wdata;
    end

    if (err_pending_q && err_rsp_ack) begin
      err_pending_d = 1'b0;
    end

    // accept already implies no error is pending, so this never races the clear.
    if (accept && unmapped) begin
      err_pending_d = 1'b1;
    end
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      hold_valid_q  <= 1'b0;
      hold_sel_q    <= '0;
      hold_wen_q    <= 1'b0;
      hold_strb_q   <= '0;
      hold_addr_q   <= '0;
      hold_wdata_q  <= '0;
      err_pending_q <= 1'b0;
    end else begin
      hold_valid_q  <= hold_valid_d;
      hold_sel_q    <= hold_sel_d;
      hold_wen_q    <= hold_wen_d;
      hold_strb_q   <= hold_strb_d;
      hold_addr_q   <= hold_addr_d;
      hold_wdata_q  <= hold_wdata_d;
      err_pending_q <= err_pending_d;
    end
  end

endmodule
